// File: rtl/cpx_stream_arbiter.sv
// rtl/cpx_stream_arbiter.sv - packet-atomic two-source CPX word-stream arbiter (optional CPX_ARB_STRICT_PRIO_EN)
module cpx_stream_arbiter #(
    parameter int PKT_WORDS = 8,
    parameter int CNT_W     = 16
) (
    input  logic             gclk,
    input  logic             grst_l,
    input  logic             src0_valid,
    input  logic [31:0]      src0_data,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [31:0]      src1_data,
    output logic             src1_ready,
    output logic             cpx_valid,
    output logic [31:0]      cpx_data,
    output logic             cpx_ctl_valid,
    output logic [31:0]      cpx_ctl_data,
    input  logic             cpx_stall,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int IDX_W = $clog2(PKT_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic [31:0]      out_ctl_q;

    logic             out_free;
    logic             accept;
    logic [31:0]      word;

    // The output register can take a new word when it is empty or its word leaves this cycle.
    // grant_q is 00 outside XFER, so both readies are 0 while idle.
    assign out_free   = !out_valid_q | !cpx_stall;
    assign src0_ready = grant_q[0] & out_free;
    assign src1_ready = grant_q[1] & out_free;
    assign accept     = ((grant_q[0] & src0_valid) | (grant_q[1] & src1_valid)) & out_free;
    assign word       = grant_q[1] ? src1_data : src0_data;

    assign cpx_valid     = out_valid_q;
    assign cpx_ctl_valid = out_valid_q;
    assign cpx_data      = out_data_q;
    assign cpx_ctl_data  = out_ctl_q;
    assign grant         = grant_q;
    assign pkt_cnt       = cnt_q;

    // State, grant, round-robin pointer and word index registers.
    always_ff @(posedge gclk) begin
        if (!grst_l) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    // Arbitration in IDLE; packet word counting and release of the grant in XFER.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (src0_valid | src1_valid) begin
                    state_d = ST_XFER;
`ifdef CPX_ARB_STRICT_PRIO_EN
                    grant_d = src0_valid ? 2'b01 : 2'b10;
`else
                    if (src0_valid & src1_valid)
                        grant_d = last_q ? 2'b01 : 2'b10;
                    else
                        grant_d = src0_valid ? 2'b01 : 2'b10;
`endif
                end
            end
            ST_XFER: begin
                if (accept) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        last_d  = grant_q[1];
                        grant_d = 2'b00;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Registered output stage: load on accept, hold while stalled, drain when the word leaves.
    always_ff @(posedge gclk) begin
        if (!grst_l) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ctl_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= word;
            out_ctl_q   <= (idx_q == '0) ? 32'hFFFF_FFFF : 32'h0000_0000;
        end else if (!cpx_stall) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completed-packet counter, bumped when the final word of a packet is accepted.
    always_ff @(posedge gclk) begin
        if (!grst_l)
            cnt_q <= '0;
        else if (accept && idx_q == LAST_IDX)
            cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_cpx_stream_arbiter.sv
// tb/tb_cpx_stream_arbiter.sv - self-checking bench for cpx_stream_arbiter
module tb_cpx_stream_arbiter;

    localparam int PW = 8;
    localparam int CW = 16;

    logic          gclk = 1'b0;
    logic          grst_l;
    logic          src0_valid, src1_valid;
    logic [31:0]   src0_data, src1_data;
    logic          src0_ready, src1_ready;
    logic          cpx_valid, cpx_ctl_valid;
    logic [31:0]   cpx_data, cpx_ctl_data;
    logic          cpx_stall;
    logic [1:0]    grant;
    logic [CW-1:0] pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Pending upstream words per source, and words expected on the CPX output in order.
    logic [31:0] sq0[$];
    logic [31:0] sq1[$];
    logic [31:0] exp_d[$];
    logic        exp_c[$];

    // Packet-level view of the arbiter.
    logic m_busy;
    int   m_src;
    int   m_idx;
    int   m_last;
    int   m_cnt;

    cpx_stream_arbiter #(.PKT_WORDS(PW), .CNT_W(CW)) dut (
        .gclk          (gclk),
        .grst_l        (grst_l),
        .src0_valid    (src0_valid),
        .src0_data     (src0_data),
        .src0_ready    (src0_ready),
        .src1_valid    (src1_valid),
        .src1_data     (src1_data),
        .src1_ready    (src1_ready),
        .cpx_valid     (cpx_valid),
        .cpx_data      (cpx_data),
        .cpx_ctl_valid (cpx_ctl_valid),
        .cpx_ctl_data  (cpx_ctl_data),
        .cpx_stall     (cpx_stall),
        .grant         (grant),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int s);
        for (int w = 0; w < PW; w++) begin
            if (s == 0) sq0.push_back($urandom);
            else        sq1.push_back($urandom);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_src  = 0;
        m_idx  = 0;
        m_last = 1;
        m_cnt  = 0;
        exp_d.delete();
        exp_c.delete();
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input logic v0, input logic v1, input logic st);
        logic       r0, r1, a0, a1, was_busy;
        logic [1:0] g;
        logic [31:0] w;
        grst_l     = 1'b1;
        src0_valid = v0 && (sq0.size() > 0);
        src1_valid = v1 && (sq1.size() > 0);
        src0_data  = (sq0.size() > 0) ? sq0[0] : 32'h0;
        src1_data  = (sq1.size() > 0) ? sq1[0] : 32'h0;
        cpx_stall  = st;
        @(negedge gclk);
        r0 = m_busy && (m_src == 0) && ((exp_d.size() == 0) || !st);
        r1 = m_busy && (m_src == 1) && ((exp_d.size() == 0) || !st);
        g  = !m_busy ? 2'b00 : ((m_src == 0) ? 2'b01 : 2'b10);
        chk("src0_ready", 32'(src0_ready), 32'(r0));
        chk("src1_ready", 32'(src1_ready), 32'(r1));
        chk("grant", 32'(grant), 32'(g));
        chk("cpx_valid", 32'(cpx_valid), 32'(exp_d.size() != 0));
        chk("cpx_ctl_valid", 32'(cpx_ctl_valid), 32'(exp_d.size() != 0));
        if (exp_d.size() != 0) begin
            chk("cpx_data", cpx_data, exp_d[0]);
            chk("cpx_ctl_data", cpx_ctl_data, exp_c[0] ? 32'hFFFF_FFFF : 32'h0);
        end
        chk("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt % (1 << CW)));
        was_busy = m_busy;
        if ((exp_d.size() != 0) && !st) begin
            void'(exp_d.pop_front());
            void'(exp_c.pop_front());
        end
        a0 = r0 && src0_valid;
        a1 = r1 && src1_valid;
        if (a0 || a1) begin
            if (a0) w = sq0.pop_front();
            else    w = sq1.pop_front();
            exp_d.push_back(w);
            exp_c.push_back(m_idx == 0);
            m_idx++;
            if (m_idx == PW) begin
                m_idx  = 0;
                m_busy = 1'b0;
                m_last = m_src;
                m_cnt++;
            end
        end else if (!was_busy && (src0_valid || src1_valid)) begin
`ifdef CPX_ARB_STRICT_PRIO_EN
            m_src = src0_valid ? 0 : 1;
`else
            if (src0_valid && src1_valid) m_src = 1 - m_last;
            else                          m_src = src0_valid ? 0 : 1;
`endif
            m_busy = 1'b1;
        end
        @(posedge gclk);
        #1;
    endtask

    // Reset for one edge; the partially sent packet is abandoned upstream.
    task automatic do_reset();
        grst_l     = 1'b0;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        cpx_stall  = 1'b0;
        @(posedge gclk);
        #1;
        if (m_busy && m_idx > 0) begin
            for (int k = 0; k < PW - m_idx; k++) begin
                if (m_src == 0) void'(sq0.pop_front());
                else            void'(sq1.pop_front());
            end
        end
        model_reset();
        chk("rst_cpx_valid", 32'(cpx_valid), 32'h0);
        chk("rst_cpx_ctl_valid", 32'(cpx_ctl_valid), 32'h0);
        chk("rst_cpx_data", cpx_data, 32'h0);
        chk("rst_cpx_ctl_data", cpx_ctl_data, 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
        chk("rst_src0_ready", 32'(src0_ready), 32'h0);
        chk("rst_src1_ready", 32'(src1_ready), 32'h0);
    endtask

    initial begin
        logic [31:0] t1 [PW];
        t1 = '{32'h0001_7000, 32'h0, 32'h0001_0001, 32'h0, 32'h0001_0001, 32'h2, 32'h0, 32'h0};
        grst_l     = 1'b0;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        src0_data  = '0;
        src1_data  = '0;
        cpx_stall  = 1'b0;
        model_reset();
        do_reset();

        // Single directed packet from src0.
        foreach (t1[i]) sq0.push_back(t1[i]);
        repeat (12) cycle(1'b1, 1'b0, 1'b0);
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("t1_grant_idle", 32'(grant), 32'd0);

        // Both sources continuously valid: alternating grants from a fresh reset.
        do_reset();
        push_pkt(0); push_pkt(1); push_pkt(0); push_pkt(1);
        repeat (40) cycle(1'b1, 1'b1, 1'b0);
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd4);

        // Stall held for five cycles while word 3 sits on the output.
        push_pkt(0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd5);

        // Granted source pauses mid-packet; src1 must not be interleaved.
        push_pkt(0); push_pkt(1);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3)  cycle(1'b1, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b1, 1'b0);
        chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd7);

        // Reset while word 5 is being offered, then src0 wins the next tie.
        push_pkt(0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        do_reset();
        push_pkt(0); push_pkt(1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t5_grant_after_reset", 32'(grant), 32'h1);
        repeat (24) cycle(1'b1, 1'b1, 1'b0);
        chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd2);

`ifdef CPX_ARB_STRICT_PRIO_EN
        // Strict priority: src1 never granted while src0 keeps offering packets.
        do_reset();
        push_pkt(0); push_pkt(0); push_pkt(0);
        push_pkt(1);
        repeat (28) cycle(1'b1, 1'b1, 1'b0);
        chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd3);
        chk("t6_src1_untouched", 32'(sq1.size()), 32'(PW));
`endif

        // Randomised valids, stalls and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if (sq0.size() < PW) push_pkt(0);
            if (sq1.size() < PW) push_pkt(1);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpx_stream_arbiter.md
# cpx_stream_arbiter

Packet-atomic two-source arbiter that merges the host memory-response and host I/O/interrupt word streams into the single 32-bit CPX word stream feeding `opensparc_t1`. It sits between the Maxeler stream inputs and the `max_cpx_*` ports of the core wrapper. It owns packet framing: it generates the control-word stream that marks header words. It also honours the core-side stall.

## Interface
Parameters:
- `PKT_WORDS`, 8: 32-bit words per CPX packet (≥2).
- `CNT_W`, 16: width of the completed-packet counter.

Ports:
- `gclk` in 1: sole clock, all logic on rising edge.
- `grst_l` in 1: reset, synchronous, active-low.
- `src0_valid` in 1: memory-response stream word valid.
- `src0_data` in 32: memory-response word.
- `src0_ready` out 1: word accepted when `src0_valid & src0_ready`.
- `src1_valid` in 1: I/O/interrupt stream word valid.
- `src1_data` in 32: I/O/interrupt word.
- `src1_ready` out 1: handshake as `src0_ready`.
- `cpx_valid` out 1: drives `max_cpx_valid`.
- `cpx_data` out 32: drives `max_cpx_data`.
- `cpx_ctl_valid` out 1: drives `max_cpx_ctl_valid`; always equal to `cpx_valid`.
- `cpx_ctl_data` out 32: 32'hFFFFFFFF on a packet's first word, 32'h00000000 otherwise.
- `cpx_stall` in 1: from `max_cpx_stall`, and also `max_cpx_ctl_stall` ORed externally.
- `grant` out 2: one-hot current owner; 2'b00 when idle.
- `pkt_cnt` out CNT_W: completed packets emitted, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, XFER.
- IDLE: `grant`=00, both readies 0.
  - If any `srcN_valid` is high, register the grant and go to XFER.
  - If both sources are valid, pick by round-robin: the source not served last wins.
  - After reset, `last` = 1, so src0 wins the first tie.
- XFER:
  - `srcG_ready = !cpx_valid | !cpx_stall`. The ungranted ready is held at 0.
  - On each accept, load the output register:
    - `cpx_valid`=1.
    - `cpx_data`=word.
    - `cpx_ctl_data`=FFFFFFFF if `word_idx`==0, else 0.
    - Increment `word_idx`.
  - If there is no accept and the output is not stalled, clear `cpx_valid`.
- Last word: on accepting the word with `word_idx`==PKT_WORDS-1:
  - `word_idx` returns to 0.
  - `last` is set to the granted source.
  - The state returns to IDLE.
  - `pkt_cnt` increments in the same cycle.
- Atomicity: a grant is never revoked mid-packet. If the granted source is not valid, the arbiter waits indefinitely; no words from the other source are interleaved.
- Output hold: while `cpx_stall`=1 and `cpx_valid`=1, `cpx_data` and `cpx_ctl_data` are held. A word counts as transferred only on a cycle with `cpx_valid & !cpx_stall`.
- Reset (`grst_l`=0 at an edge):
  - IDLE, `word_idx`=0, `last`=1.
  - `cpx_valid`=`cpx_ctl_valid`=0.
  - `cpx_data`=`cpx_ctl_data`=0.
  - `grant`=00, `pkt_cnt`=0, readies 0.
  - Reset mid-packet discards the partial packet. Upstream must re-send whole packets.

## Timing
- Source accept to `cpx_valid`: 1 cycle, registered output. There is no combinational path from `srcN_valid` to `cpx_*`.
- `cpx_stall` to `srcN_ready`: combinational, one gate level.
- IDLE arbitration costs 1 cycle, so there is a minimum 1-cycle gap on `srcN_ready` between packets. Peak throughput is PKT_WORDS per PKT_WORDS+1 cycles.
- Continuous stall: zero words accepted, output held. When stall is released, the held word transfers in that cycle and a new word may be accepted in the same cycle.
- Both valid in the same IDLE cycle as a source deasserts: the decision uses only the sampled valids of that cycle.

## Configuration
- `CPX_ARB_STRICT_PRIO_EN`:
  - Defined: src0 (memory responses) always wins in IDLE when valid, and `last` is ignored. src1 may starve.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset then single packet: src0 presents words 00017000, 0, 00010001, 0, 00010001, 2, 0, 0 with `cpx_stall`=0.
  - `grant`=01 one cycle later.
  - `cpx_data` replays the words on 8 consecutive cycles, with `cpx_ctl_data`=FFFFFFFF on the first word only.
  - `pkt_cnt`=1 afterwards, `grant`=00.
- Both sources continuously valid for 4 packets: grant order is src0, src1, src0, src1, with no word interleaving and `pkt_cnt`=4.
- Stall mid-packet: assert `cpx_stall` while word 3 is on the output, for 5 cycles.
  - `cpx_data` is held for 5 cycles and readies stay 0.
  - Words 4–7 follow after release, and no word is lost or duplicated.
- Granted source drops valid after word 2 for 10 cycles while src1 is valid: `src1_ready` stays 0, and the packet completes with the src0 remainder.
- Assert `grst_l`=0 during word 5, then release: all outputs return to reset values. The next packet starts with FFFFFFFF control and src0 wins the tie.
- `CPX_ARB_STRICT_PRIO_EN` defined, both sources always valid: 3 consecutive src0 packets and zero src1 grants.
